clint_timer: RTL and testbench
==============================

# clint_timer

Machine-level core-local interruptor: holds the memory-mapped `msip`, `mtimecmp` and `mtime` registers, advances `mtime` from a programmable prescaler, and raises registered machine timer and software interrupt-pending lines. The block sits on the data-memory bus beside the LSU. Its `mtip`/`msip` outputs feed the interrupt half of the CSR unit's exception vector (`csr_vec[63:32]`), where they are gated by `mie`/`mstatus.MIE`.

## Interface
- `BASE_ADDR`, default `64'h0200_0000`: CLINT base; decoded offsets are `+0x0000` msip, `+0x4000` mtimecmp, `+0xBFF8` mtime.
- `TICK_DIV`, default `1`: clock cycles per `mtime` increment; must be ≥1.

Ports:
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `req_valid` in, 1: bus request valid.
- `req_ready` out, 1: block can accept a request.
- `req_we` in, 1: 1 = write, 0 = read.
- `req_addr` in, 64: byte address; `[2:0]` ignored (64-bit aligned).
- `req_wdata` in, 64: write data.
- `req_wstrb` in, 8: byte enables for writes.
- `resp_valid` out, 1: response valid.
- `resp_ready` in, 1: consumer accepts the response.
- `resp_rdata` out, 64: read data; 0 for writes.
- `resp_err` out, 1: unmapped address.
- `mtip` out, 1: machine timer interrupt pending.
- `msip` out, 1: machine software interrupt pending.
- `mtime_o` out, 64: current `mtime`, for debug and the difftest.

## Operation
- **Reset values:** `mtime`=0, `mtimecmp`=all ones, msip reg=0, prescaler=0, `mtip`=0, `msip`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- **Prescaler:** counts 0..TICK_DIV-1. On a terminal count it wraps to 0 and increments `mtime` by 1. `mtime` wraps from `2^64-1` to 0 with no flag.
- **Request acceptance:** a request is accepted when `req_valid & req_ready`.
  - `req_ready = !resp_valid | resp_ready`.
  - One outstanding response at most.
- **Write:** for each byte with `wstrb[i]`=1, byte i of the target register is replaced.
  - msip register keeps only bit 0; upper bits read 0.
  - A write to `mtime` in the same cycle as a tick wins, and the tick is dropped for that cycle. The prescaler still advances.
- **Read:** returns the register value at acceptance, before any same-cycle tick.
- **Unmapped address** within or outside the base: reads return 0, writes are ignored, `resp_err`=1.
- **mtip:** registered `mtime >= mtimecmp` (unsigned, 64-bit), evaluated on register values of the previous cycle.
- **msip:** registered copy of msip bit 0.

## Timing
- **Response latency:** 1 cycle. A request accepted at edge t gives `resp_valid`=1 after edge t, held with stable data until `resp_ready`.
- **Back-to-back:** with `resp_ready`=1 continuously, one request per cycle is accepted.
- **Write visibility:** a register written at edge t is visible to a read accepted at edge t+1.
- **Interrupt lag:** a write to `mtimecmp` at edge t affects `mtip` at edge t+1. `mtip` deasserts on the cycle after a compare value greater than `mtime` is written.
- **Divided tick:** with TICK_DIV=N, `mtime` increments on every N-th edge after reset release.
- **Reset mid-transaction:** any pending response is dropped (`resp_valid`=0 the cycle after `rst`). Registers return to reset values; no partial write survives.

## Structure
- Package `clint_pkg`:
  - offsets `CLINT_MSIP_OFF`, `CLINT_MTIMECMP_OFF`, `CLINT_MTIME_OFF`;
  - reset constant `MTIMECMP_RST`;
  - function `apply_wstrb(old, wdata, wstrb)`.
- Sub-module `clint_prescaler`: parameter TICK_DIV; inputs `clk`, `rst`; output `tick` (1-cycle pulse).
- Top level: address decode, register file, response register, compare flops.

## Test plan
- Release reset with TICK_DIV=1 and idle for 10 cycles → `mtime_o`=10, `mtip`=0, `msip`=0, a read of `mtimecmp` returns `64'hFFFF_FFFF_FFFF_FFFF`.
- Write `mtimecmp`=20 with wstrb=`8'hFF`, then wait → `mtip` rises on the cycle after `mtime`=20. Writing `mtimecmp`=1000 clears `mtip` one cycle later.
- Write `mtime`=`64'h1234` in a tick cycle, then read next cycle → reads `64'h1235`; the written value wins over the tick.
- Write msip=`64'hFFFF_FFFF` → `msip`=1 next cycle, and a readback gives `64'h1`. Write 0 → `msip`=0.
- Partial write: wstrb=`8'h0F`, data `64'hAAAA_AAAA_5555_5555` to `mtimecmp` (reset value) → reads `64'hFFFF_FFFF_5555_5555`. An unmapped read at `+0x8` → rdata 0 with `resp_err`=1.
- Hold `resp_ready`=0 for 3 cycles after a read → `resp_valid` and `resp_rdata` stay stable and `req_ready`=0. Assert `rst` during the stall → `resp_valid`=0 next cycle and `mtime`=0.

Source files
------------

// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - shared offsets, reset constants and byte-merge helper for the CLINT
package clint_pkg;

    localparam logic [63:0] CLINT_MSIP_OFF     = 64'h0000_0000_0000_0000;
    localparam logic [63:0] CLINT_MTIMECMP_OFF = 64'h0000_0000_0000_4000;
    localparam logic [63:0] CLINT_MTIME_OFF    = 64'h0000_0000_0000_BFF8;

    // A compare value of all ones keeps mtip low until software programs it
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_MTIMECMP,
        SEL_MTIME
    } clint_sel_e;

    // Replace byte i of old with byte i of wdata wherever wstrb[i] is set
    function automatic logic [63:0] apply_wstrb(input logic [63:0] old,
                                                input logic [63:0] wdata,
                                                input logic [7:0]  wstrb);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (wstrb[i]) begin
                r[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// rtl/clint_prescaler.sv - divides the clock into mtime increment ticks
module clint_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Terminal count; with TICK_DIV=1 this is high every cycle
    assign tick = (cnt == LAST);

    // Count 0..TICK_DIV-1 and wrap on the terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - core-local interruptor: msip, mtimecmp, mtime and interrupt lines
module clint_timer
    import clint_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mtip,
    output logic        msip,
    output logic [63:0] mtime_o
);

    localparam logic [63:0] ADDR_MSIP     = BASE_ADDR + CLINT_MSIP_OFF;
    localparam logic [63:0] ADDR_MTIMECMP = BASE_ADDR + CLINT_MTIMECMP_OFF;
    localparam logic [63:0] ADDR_MTIME    = BASE_ADDR + CLINT_MTIME_OFF;

    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip_reg;
    logic        accept;
    clint_sel_e  sel;
    logic [63:0] rd_mux;
    logic        wr_msip;
    logic        wr_mtimecmp;
    logic        wr_mtime;
    logic        unused_addr;

    clint_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Registers are 64-bit aligned, so the low address bits never take part in decode
    assign unused_addr = ^req_addr[2:0];

    assign req_ready = !resp_valid | resp_ready;
    assign accept    = req_valid & req_ready;
    assign mtime_o   = mtime;

    // Address decode and read mux on the pre-edge register values
    always_comb begin
        sel    = SEL_NONE;
        rd_mux = '0;
        if (req_addr[63:3] == ADDR_MSIP[63:3]) begin
            sel    = SEL_MSIP;
            rd_mux = {63'b0, msip_reg};
        end else if (req_addr[63:3] == ADDR_MTIMECMP[63:3]) begin
            sel    = SEL_MTIMECMP;
            rd_mux = mtimecmp;
        end else if (req_addr[63:3] == ADDR_MTIME[63:3]) begin
            sel    = SEL_MTIME;
            rd_mux = mtime;
        end
    end

    assign wr_msip     = accept & req_we & (sel == SEL_MSIP);
    assign wr_mtimecmp = accept & req_we & (sel == SEL_MTIMECMP);
    assign wr_mtime    = accept & req_we & (sel == SEL_MTIME);

    // Register file; a bus write to mtime overrides the tick in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime    <= '0;
            mtimecmp <= MTIMECMP_RST;
            msip_reg <= 1'b0;
        end else begin
            if (wr_mtime) begin
                mtime <= apply_wstrb(mtime, req_wdata, req_wstrb);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
            if (wr_mtimecmp) begin
                mtimecmp <= apply_wstrb(mtimecmp, req_wdata, req_wstrb);
            end
            // Only bit 0 is implemented, and it lives in byte lane 0
            if (wr_msip && req_wstrb[0]) begin
                msip_reg <= req_wdata[0];
            end
        end
    end

    // Interrupt lines track the previous cycle's register values
    always_ff @(posedge clk) begin
        if (rst) begin
            mtip <= 1'b0;
            msip <= 1'b0;
        end else begin
            mtip <= (mtime >= mtimecmp);
            msip <= msip_reg;
        end
    end

    // Single-entry response register; data holds until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_rdata <= (req_we || sel == SEL_NONE) ? 64'd0 : rd_mux;
            resp_err   <= (sel == SEL_NONE);
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - directed and randomized checks of clint_timer against a behavioural model
module tb_clint_timer;

    localparam logic [63:0] BASE  = 64'h0200_0000;
    localparam logic [63:0] A_SIP = BASE;
    localparam logic [63:0] A_CMP = BASE + 64'h4000;
    localparam logic [63:0] A_TIM = BASE + 64'hBFF8;
    localparam int          DIV   = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mtip;
    logic        msip;
    logic [63:0] mtime_o;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [63:0] m_time, m_cmp, m_rdata;
    logic        m_sip, m_mtip, m_msip_o, m_rv, m_err;
    int          m_pre;

    clint_timer #(
        .BASE_ADDR (BASE),
        .TICK_DIV  (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mtip       (mtip),
        .msip       (msip),
        .mtime_o    (mtime_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    // One clock: predict from pre-edge inputs, advance, then compare every output
    task automatic step();
        logic        ready, acc, tk;
        logic [63:0] off, rv, n_time, n_cmp, n_rdata;
        logic        n_sip, n_mtip, n_msip_o, n_rv, n_err;
        int          kind, n_pre;
        #1;
        ready = !m_rv || resp_ready;
        if (!rst) chk("req_ready", {63'b0, req_ready}, {63'b0, ready});
        acc  = req_valid && ready;
        off  = (req_addr - BASE) & ~64'h7;
        kind = (off == 64'h0) ? 0 : (off == 64'h4000) ? 1 : (off == 64'hBFF8) ? 2 : 3;
        tk       = (m_pre == DIV - 1);
        n_pre    = tk ? 0 : m_pre + 1;
        n_time   = m_time + (tk ? 64'd1 : 64'd0);
        n_cmp    = m_cmp;
        n_sip    = m_sip;
        n_mtip   = (m_time >= m_cmp);
        n_msip_o = m_sip;
        n_rv     = m_rv;
        n_rdata  = m_rdata;
        n_err    = m_err;
        if (acc) begin
            rv = (kind == 0) ? {63'b0, m_sip} : (kind == 1) ? m_cmp : (kind == 2) ? m_time : 64'd0;
            if (req_we) begin
                if (kind == 0) n_sip  = merge({63'b0, m_sip}, req_wdata, req_wstrb) & 64'h1;
                if (kind == 1) n_cmp  = merge(m_cmp, req_wdata, req_wstrb);
                if (kind == 2) n_time = merge(m_time, req_wdata, req_wstrb);
            end
            n_rv    = 1'b1;
            n_rdata = req_we ? 64'd0 : rv;
            n_err   = (kind == 3);
        end else if (resp_ready) begin
            n_rv = 1'b0;
        end
        if (rst) begin
            n_pre = 0; n_time = 0; n_cmp = '1; n_sip = 0; n_mtip = 0; n_msip_o = 0;
            n_rv = 0; n_rdata = 0; n_err = 0;
        end
        @(posedge clk);
        #1;
        m_pre = n_pre; m_time = n_time; m_cmp = n_cmp; m_sip = n_sip; m_mtip = n_mtip;
        m_msip_o = n_msip_o; m_rv = n_rv; m_rdata = n_rdata; m_err = n_err;
        chk("mtime_o", mtime_o, m_time);
        chk("mtip", {63'b0, mtip}, {63'b0, m_mtip});
        chk("msip", {63'b0, msip}, {63'b0, m_msip_o});
        chk("resp_valid", {63'b0, resp_valid}, {63'b0, m_rv});
        if (m_rv) begin
            chk("resp_rdata", resp_rdata, m_rdata);
            chk("resp_err", {63'b0, resp_err}, {63'b0, m_err});
        end
    endtask

    task automatic put(input logic we, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] s);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] hold;
        int          k;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; resp_ready = 1'b1;
        m_time = 0; m_cmp = '1; m_sip = 0; m_mtip = 0; m_msip_o = 0;
        m_rv = 0; m_rdata = 0; m_err = 0; m_pre = 0;
        step();
        step();
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", {63'b0, resp_err}, 64'd0);
        rst = 1'b0;

        // Idle after reset, then read the reset compare value
        repeat (10) step();
        chk("idle_mtime", mtime_o, 64'd10);
        chk("idle_mtip", {63'b0, mtip}, 64'd0);
        chk("idle_msip", {63'b0, msip}, 64'd0);
        put(1'b0, A_CMP, 64'd0, 8'h00);
        chk("cmp_rst_read", resp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);

        // Timer interrupt rises the cycle after mtime reaches 20, clears after a later compare
        put(1'b1, A_CMP, 64'd20, 8'hFF);
        for (int i = 0; i < 100 && mtime_o != 64'd20; i++) step();
        chk("wait_mtime20", mtime_o, 64'd20);
        chk("mtip_before", {63'b0, mtip}, 64'd0);
        step();
        chk("mtip_rise", {63'b0, mtip}, 64'd1);
        put(1'b1, A_CMP, 64'd1000, 8'hFF);
        chk("mtip_lag", {63'b0, mtip}, 64'd1);
        step();
        chk("mtip_clear", {63'b0, mtip}, 64'd0);

        // Write to mtime beats the tick of the same cycle
        put(1'b1, A_TIM, 64'h1234, 8'hFF);
        chk("mtime_wr_wins", mtime_o, 64'h1234);
        step();
        put(1'b0, A_TIM, 64'd0, 8'h00);
        chk("mtime_read", resp_rdata, 64'h1235);

        // Software interrupt bit
        put(1'b1, A_SIP, 64'hFFFF_FFFF, 8'hFF);
        step();
        chk("msip_set", {63'b0, msip}, 64'd1);
        put(1'b0, A_SIP, 64'd0, 8'h00);
        chk("msip_read", resp_rdata, 64'h1);
        put(1'b1, A_SIP, 64'd0, 8'hFF);
        step();
        chk("msip_clr", {63'b0, msip}, 64'd0);

        // Partial write onto the reset compare value, then an unmapped read
        rst = 1'b1;
        step();
        rst = 1'b0;
        put(1'b1, A_CMP, 64'hAAAA_AAAA_5555_5555, 8'h0F);
        put(1'b0, A_CMP, 64'd0, 8'h00);
        chk("partial_wr", resp_rdata, 64'hFFFF_FFFF_5555_5555);
        put(1'b0, BASE + 64'h8, 64'd0, 8'h00);
        chk("unmapped_data", resp_rdata, 64'd0);
        chk("unmapped_err", {63'b0, resp_err}, 64'd1);

        // Back-pressure holds the response; reset during the stall drops it
        put(1'b0, A_TIM, 64'd0, 8'h00);
        hold = m_rdata;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = A_CMP;
        repeat (3) begin
            step();
            chk("stall_valid", {63'b0, resp_valid}, 64'd1);
            chk("stall_data", resp_rdata, hold);
            chk("stall_ready", {63'b0, req_ready}, 64'd0);
        end
        rst = 1'b1;
        step();
        chk("rst_drop_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst_mtime", mtime_o, 64'd0);
        rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 63) == 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            req_valid  = ($urandom_range(0, 2) != 0);
            req_we     = $urandom_range(0, 1);
            k          = $urandom_range(0, 4);
            req_addr   = (k == 0) ? A_SIP : (k == 1) ? A_CMP : (k == 2) ? A_TIM :
                         (k == 3) ? BASE + 64'h4008 : 64'h0000_0000_0000_BFF8;
            req_addr   = req_addr | 64'($urandom_range(0, 7));
            req_wdata  = m_time + 64'($urandom_range(0, 40)) - 64'd20;
            req_wstrb  = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom_range(0, 255));
            step();
        end
        rst = 1'b0; req_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
